// File: rtl/opl_pkg.sv
// Shared OPL waveform-path types: waveform selects, datapath widths, decode records.
// Latency: n/a (types, constants and a pure mirror helper only).
// Backpressure: n/a.
package opl_pkg;

  localparam int OPL_PHASE_W = 10;
  localparam int OPL_ATTEN_W = 12;
  localparam logic [OPL_ATTEN_W-1:0] OPL_MUTE_ATTEN = 12'hFFF;

  typedef enum logic [2:0] {
    WAVE_SINE    = 3'd0,
    WAVE_HALF    = 3'd1,
    WAVE_ABS     = 3'd2,
    WAVE_PULSE   = 3'd3,
    WAVE_ALT     = 3'd4,
    WAVE_CAMEL   = 3'd5,
    WAVE_SQUARE  = 3'd6,
    WAVE_DSQUARE = 3'd7
  } opl_wave_e;

  // Per-sample control that must travel past the ROM read stage.
  typedef struct packed {
    logic                   byp;    // ROM result ignored, use atten below
    logic [OPL_ATTEN_W-1:0] atten;  // attenuation for ROM-bypass waveforms
    logic                   sign;
    logic                   mute;
  } opl_ctl_t;

  // Full decode result: ROM index plus the control carried alongside it.
  typedef struct packed {
    logic [7:0] idx;
    opl_ctl_t   ctl;
  } opl_dec_t;

  // Quarter-wave mirror: the second quarter of each half-cycle reads the
  // table backwards.
  function automatic logic [7:0] opl_mirror(input logic [8:0] x);
    return x[8] ? ~x[7:0] : x[7:0];
  endfunction

endpackage

// File: rtl/opl_quarter_sine_rom.sv
// Quarter-wave log-sine table, q[i] = round(-log2(sin((i+0.5)*pi/512))*256), 256 x 12 bit.
// Latency: 1 cycle (registered read output).
// Backpressure: en=0 holds the output register.
// Ports: clk; en (read/advance); idx[7:0] table index; data[11:0] registered table word.
module opl_quarter_sine_rom (
  input  logic        clk,
  input  logic        en,
  input  logic [7:0]  idx,
  output logic [11:0] data
);

  localparam logic [11:0] LOGSIN [256] = '{
    12'h859, 12'h6c3, 12'h607, 12'h58b, 12'h52e, 12'h4e4, 12'h4a6, 12'h471, 12'h443, 12'h41a, 12'h3f5, 12'h3d3, 12'h3b5, 12'h398, 12'h37e, 12'h365,
    12'h34e, 12'h339, 12'h324, 12'h311, 12'h2ff, 12'h2ed, 12'h2dc, 12'h2cd, 12'h2bd, 12'h2af, 12'h2a0, 12'h293, 12'h286, 12'h279, 12'h26d, 12'h261,
    12'h256, 12'h24b, 12'h240, 12'h236, 12'h22c, 12'h222, 12'h218, 12'h20f, 12'h206, 12'h1fd, 12'h1f5, 12'h1ec, 12'h1e4, 12'h1dc, 12'h1d4, 12'h1cd,
    12'h1c5, 12'h1be, 12'h1b7, 12'h1b0, 12'h1a9, 12'h1a2, 12'h19b, 12'h195, 12'h18f, 12'h188, 12'h182, 12'h17c, 12'h177, 12'h171, 12'h16b, 12'h166,
    12'h160, 12'h15b, 12'h155, 12'h150, 12'h14b, 12'h146, 12'h141, 12'h13c, 12'h137, 12'h133, 12'h12e, 12'h129, 12'h125, 12'h121, 12'h11c, 12'h118,
    12'h114, 12'h10f, 12'h10b, 12'h107, 12'h103, 12'h0ff, 12'h0fb, 12'h0f8, 12'h0f4, 12'h0f0, 12'h0ec, 12'h0e9, 12'h0e5, 12'h0e2, 12'h0de, 12'h0db,
    12'h0d7, 12'h0d4, 12'h0d1, 12'h0cd, 12'h0ca, 12'h0c7, 12'h0c4, 12'h0c1, 12'h0be, 12'h0bb, 12'h0b8, 12'h0b5, 12'h0b2, 12'h0af, 12'h0ac, 12'h0a9,
    12'h0a7, 12'h0a4, 12'h0a1, 12'h09f, 12'h09c, 12'h099, 12'h097, 12'h094, 12'h092, 12'h08f, 12'h08d, 12'h08a, 12'h088, 12'h086, 12'h083, 12'h081,
    12'h07f, 12'h07d, 12'h07a, 12'h078, 12'h076, 12'h074, 12'h072, 12'h070, 12'h06e, 12'h06c, 12'h06a, 12'h068, 12'h066, 12'h064, 12'h062, 12'h060,
    12'h05e, 12'h05c, 12'h05b, 12'h059, 12'h057, 12'h055, 12'h053, 12'h052, 12'h050, 12'h04e, 12'h04d, 12'h04b, 12'h04a, 12'h048, 12'h046, 12'h045,
    12'h043, 12'h042, 12'h040, 12'h03f, 12'h03e, 12'h03c, 12'h03b, 12'h039, 12'h038, 12'h037, 12'h035, 12'h034, 12'h033, 12'h031, 12'h030, 12'h02f,
    12'h02e, 12'h02d, 12'h02b, 12'h02a, 12'h029, 12'h028, 12'h027, 12'h026, 12'h025, 12'h024, 12'h023, 12'h022, 12'h021, 12'h020, 12'h01f, 12'h01e,
    12'h01d, 12'h01c, 12'h01b, 12'h01a, 12'h019, 12'h018, 12'h017, 12'h017, 12'h016, 12'h015, 12'h014, 12'h014, 12'h013, 12'h012, 12'h011, 12'h011,
    12'h010, 12'h00f, 12'h00f, 12'h00e, 12'h00d, 12'h00d, 12'h00c, 12'h00c, 12'h00b, 12'h00a, 12'h00a, 12'h009, 12'h009, 12'h008, 12'h008, 12'h007,
    12'h007, 12'h007, 12'h006, 12'h006, 12'h005, 12'h005, 12'h005, 12'h004, 12'h004, 12'h004, 12'h003, 12'h003, 12'h003, 12'h002, 12'h002, 12'h002,
    12'h002, 12'h001, 12'h001, 12'h001, 12'h001, 12'h001, 12'h001, 12'h001, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000
  };

  logic [11:0] data_d;
  logic [11:0] data_q;

  always_comb begin
    data_d = data_q;
    if (en) begin
      data_d = LOGSIN[idx];
    end
  end

  // Table output needs no reset: downstream valid bits qualify it.
  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign data = data_q;

endmodule

// File: rtl/opl_wave_atten_pipe.sv
// Time-multiplexed OPL2/OPL3 waveform generator in the log domain: phase + wave -> attenuation/sign/mute.
// Latency: 3 en-cycles (S1 decode, S2 table read, S3 mute/bypass select); one sample per en-cycle.
// Backpressure: en=0 freezes every stage and ignores inputs; rst (sync, active-high) overrides en.
// Ports: clk, rst, en; in_valid/in_phase[9:0]/in_wave[2:0]/in_tag in; out_valid/out_atten[11:0]/
//        out_sign/out_mute/out_tag out (out_* hold the last valid sample while out_valid=0).
module opl_wave_atten_pipe
  import opl_pkg::*;
#(
  parameter int                     NUM_WAVES = 4,
  parameter int                     TAG_W     = 5,
  parameter logic [OPL_ATTEN_W-1:0] MUTE_VAL  = OPL_MUTE_ATTEN
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   in_valid,
  input  logic [OPL_PHASE_W-1:0] in_phase,
  input  logic [2:0]             in_wave,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  output logic [OPL_ATTEN_W-1:0] out_atten,
  output logic                   out_sign,
  output logic                   out_mute,
  output logic [TAG_W-1:0]       out_tag
);

  generate
    if (NUM_WAVES != 4 && NUM_WAVES != 8) begin : g_bad_num_waves
      $error("opl_wave_atten_pipe: NUM_WAVES must be 4 or 8");
    end
  endgenerate

  // ---------------------------------------------------------------- S1 decode
  logic [2:0] wave_sel;
  logic [8:0] alt_phase;  // phase doubled within one half-cycle (alt/camel)
  opl_dec_t   dec;

  always_comb begin
    // OPL2 mode only knows waves 0-3, so the top select bit is dropped.
    wave_sel  = {(NUM_WAVES == 8) && in_wave[2], in_wave[1:0]};
    alt_phase = {in_phase[7:0], 1'b0};
    dec       = '0;
    case (wave_sel)
      WAVE_SINE: begin
        dec.idx      = opl_mirror(in_phase[8:0]);
        dec.ctl.sign = in_phase[9];
      end
      WAVE_HALF: begin
        dec.idx      = opl_mirror(in_phase[8:0]);
        dec.ctl.sign = in_phase[9];
        dec.ctl.mute = in_phase[9];
      end
      WAVE_ABS: begin
        dec.idx = opl_mirror(in_phase[8:0]);
      end
      WAVE_PULSE: begin
        dec.idx      = in_phase[7:0];
        dec.ctl.mute = in_phase[8];
      end
      WAVE_ALT: begin
        dec.idx      = opl_mirror(alt_phase);
        dec.ctl.sign = in_phase[8];
        dec.ctl.mute = in_phase[9];
      end
      WAVE_CAMEL: begin
        dec.idx      = opl_mirror(alt_phase);
        dec.ctl.mute = in_phase[9];
      end
      WAVE_SQUARE: begin
        dec.ctl.byp  = 1'b1;
        dec.ctl.sign = in_phase[9];
      end
      WAVE_DSQUARE: begin
        // Linear ramp in the log domain: rises through the first half-cycle,
        // falls back through the second.
        dec.ctl.byp   = 1'b1;
        dec.ctl.atten = {(in_phase[9] ? ~in_phase[8:0] : in_phase[8:0]), 3'b000};
        dec.ctl.sign  = in_phase[9];
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------- pipeline state
  logic                   s1_vld_d, s1_vld_q;
  opl_dec_t               s1_dec_d, s1_dec_q;
  logic [TAG_W-1:0]       s1_tag_d, s1_tag_q;

  logic                   s2_vld_d, s2_vld_q;
  opl_ctl_t               s2_ctl_d, s2_ctl_q;
  logic [TAG_W-1:0]       s2_tag_d, s2_tag_q;

  logic                   out_vld_d, out_vld_q;
  logic [OPL_ATTEN_W-1:0] out_atten_d, out_atten_q;
  logic                   out_sign_d, out_sign_q;
  logic                   out_mute_d, out_mute_q;
  logic [TAG_W-1:0]       out_tag_d, out_tag_q;

  logic [OPL_ATTEN_W-1:0] rom_data;

  // ---------------------------------------------------------------- S2 table read
  // The table register only loads for real samples, keeping it aligned with s2.
  opl_quarter_sine_rom u_rom (
    .clk  (clk),
    .en   (en & s1_vld_q),
    .idx  (s1_dec_q.idx),
    .data (rom_data)
  );

  // ---------------------------------------------------------------- stage advance / S3 select
  always_comb begin
    s1_vld_d    = s1_vld_q;
    s1_dec_d    = s1_dec_q;
    s1_tag_d    = s1_tag_q;
    s2_vld_d    = s2_vld_q;
    s2_ctl_d    = s2_ctl_q;
    s2_tag_d    = s2_tag_q;
    out_vld_d   = out_vld_q;
    out_atten_d = out_atten_q;
    out_sign_d  = out_sign_q;
    out_mute_d  = out_mute_q;
    out_tag_d   = out_tag_q;

    if (rst) begin
      s1_vld_d    = 1'b0;
      s2_vld_d    = 1'b0;
      out_vld_d   = 1'b0;
      out_atten_d = '0;
      out_sign_d  = 1'b0;
      out_mute_d  = 1'b0;
      out_tag_d   = '0;
    end else if (en) begin
      s1_vld_d = in_valid;
      if (in_valid) begin
        s1_dec_d = dec;
        s1_tag_d = in_tag;
      end

      s2_vld_d = s1_vld_q;
      if (s1_vld_q) begin
        s2_ctl_d = s1_dec_q.ctl;
        s2_tag_d = s1_tag_q;
      end

      out_vld_d = s2_vld_q;
      if (s2_vld_q) begin
        out_sign_d = s2_ctl_q.sign;
        out_mute_d = s2_ctl_q.mute;
        out_tag_d  = s2_tag_q;
        if (s2_ctl_q.mute) begin
          out_atten_d = MUTE_VAL;
        end else if (s2_ctl_q.byp) begin
          out_atten_d = s2_ctl_q.atten;
        end else begin
          out_atten_d = rom_data;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    s1_vld_q    <= s1_vld_d;
    s1_dec_q    <= s1_dec_d;
    s1_tag_q    <= s1_tag_d;
    s2_vld_q    <= s2_vld_d;
    s2_ctl_q    <= s2_ctl_d;
    s2_tag_q    <= s2_tag_d;
    out_vld_q   <= out_vld_d;
    out_atten_q <= out_atten_d;
    out_sign_q  <= out_sign_d;
    out_mute_q  <= out_mute_d;
    out_tag_q   <= out_tag_d;
  end

  assign out_valid = out_vld_q;
  assign out_atten = out_atten_q;
  assign out_sign  = out_sign_q;
  assign out_mute  = out_mute_q;
  assign out_tag   = out_tag_q;

endmodule
